dsc_mul_es_ctrl: RTL and testbench

//  Operand-sequencing controller for the serial deterministic stochastic multiplier core (4b, early-shutoff variant).

---
 rtl/dsc_pkg.sv | 20 ++
 rtl/dsc_cyc_counter.sv | 31 +++
 rtl/dsc_mul_es_ctrl.sv | 156 +++++++++++++++
 tb/tb_dsc_mul_es_ctrl.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dsc_pkg.sv
// -----------------------------------------------------------------------------
// dsc_pkg
//  Shared constants for the deterministic stochastic multiplier control slice.
//  SNG_WIDTH  : operand width of the stochastic number generators / core.
//  RUN_LIMIT  : longest possible RUN phase in cycles (2^(2*SNG_WIDTH)); after
//               that many cycles the core counter holds the exact product.
//  ST_*       : controller FSM encodings.
// -----------------------------------------------------------------------------
package dsc_pkg;

   localparam int SNG_WIDTH = 4;
   localparam int RUN_LIMIT = 2 ** (2 * SNG_WIDTH);

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_CLEAR = 3'd1;
   localparam logic [2:0] ST_RUN   = 3'd2;
   localparam logic [2:0] ST_DRAIN = 3'd3;
   localparam logic [2:0] ST_HOLD  = 3'd4;

endpackage

// File: rtl/dsc_cyc_counter.sv
// -----------------------------------------------------------------------------
// dsc_cyc_counter
//  Saturating up-counter with enable and synchronous clear.
//  Ports:
//   clk    in   clock
//   rst    in   asynchronous active-high reset (count -> 0)
//   en     in   count one step this cycle
//   clr    in   synchronous clear, has priority over en
//   count  out  current count, sticks at all-ones
// -----------------------------------------------------------------------------
module dsc_cyc_counter #(
   parameter int WIDTH = 9
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             clr,
   output logic [WIDTH-1:0] count
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (en && (count != {WIDTH{1'b1}})) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/dsc_mul_es_ctrl.sv
// -----------------------------------------------------------------------------
// dsc_mul_es_ctrl
//  Operand-sequencing controller around the serial deterministic stochastic
//  multiplier core (early-shutoff variant). Takes an operand pair on a
//  valid/ready handshake, clears and runs the core until it reports ov (after
//  a short start-up mask) or the full 2^(2W)-cycle window has elapsed, then
//  returns the core's product count with the RUN cycle count and a stop flag.
//
//  State table:
//   state  | meaning
//   IDLE   | in_ready=1, waiting for an operand pair
//   CLEAR  | one-cycle core clear (mul_rst=1, mul_en=0)
//   RUN    | core enabled, counting RUN cycles, watching ov / limit
//   DRAIN  | core disabled one cycle so its output counter settles
//   HOLD   | result presented, out_valid=1 until out_ready
//
//  Ports:
//   clk, rst              clock, asynchronous active-high reset
//   in_valid/in_ready     operand handshake, in_a/in_b operands (W bits)
//   out_valid/out_ready   result handshake
//   out_z     (2W)        captured product count
//   out_cyc   (2W+1)      RUN cycles used
//   out_early             1 = ov stop or zero bypass, 0 = cycle-limit stop
//   mul_a/mul_b           operands to core, held for the whole operation
//   mul_en/mul_rst        core enable / registered core clear
//   mul_z/mul_ov          core product count / early-shutoff indication
// -----------------------------------------------------------------------------
module dsc_mul_es_ctrl
   import dsc_pkg::*;
#(
   parameter int W         = SNG_WIDTH,
   parameter int IGNORE_OV = 2
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [W-1:0]   in_a,
   input  logic [W-1:0]   in_b,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [2*W-1:0] out_z,
   output logic [2*W:0]   out_cyc,
   output logic           out_early,
   output logic [W-1:0]   mul_a,
   output logic [W-1:0]   mul_b,
   output logic           mul_en,
   output logic           mul_rst,
   input  logic [2*W-1:0] mul_z,
   input  logic           mul_ov
);

   localparam int CW = 2 * W + 1;
   // Count value seen during the last permitted RUN cycle.
   localparam logic [CW-1:0] LIM_M1  = CW'((2 ** (2 * W)) - 1);
   localparam logic [CW-1:0] OV_MASK = CW'(IGNORE_OV);

   logic [2:0]    state;
   logic [2:0]    state_nxt;
   logic [CW-1:0] cnt;
   logic          accept;
   logic          zero_op;
   logic          in_run;
   logic          stop_ov;
   logic          stop_lim;

   assign accept  = in_valid & in_ready;
   assign zero_op = (in_a == '0) | (in_b == '0);
   assign in_run  = (state == ST_RUN);

   // The core's ~sn_out_b path can glitch ov right after a clear, so ov is
   // only trusted once the counter has passed the mask window.
   assign stop_ov  = in_run & mul_ov & (cnt >= OV_MASK);
   assign stop_lim = in_run & (cnt == LIM_M1);

   dsc_cyc_counter #(
      .WIDTH (CW)
   ) u_cyc_counter (
      .clk   (clk),
      .rst   (rst),
      .en    (in_run),
      .clr   (accept),
      .count (cnt)
   );

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: begin
            if (accept) begin
               state_nxt = zero_op ? ST_HOLD : ST_CLEAR;
            end
         end
         ST_CLEAR: state_nxt = ST_RUN;
         ST_RUN: begin
            if (stop_ov || stop_lim) begin
               state_nxt = ST_DRAIN;
            end
         end
         ST_DRAIN: state_nxt = ST_HOLD;
         ST_HOLD: begin
            if (out_ready) begin
               state_nxt = ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Handshake and core controls are decoded from the next state so every
   // output comes straight from a flop.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         mul_en    <= 1'b0;
         mul_rst   <= 1'b1;
      end else begin
         state     <= state_nxt;
         in_ready  <= (state_nxt == ST_IDLE);
         out_valid <= (state_nxt == ST_HOLD);
         mul_en    <= (state_nxt == ST_RUN);
         mul_rst   <= (state_nxt == ST_CLEAR);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mul_a     <= '0;
         mul_b     <= '0;
         out_z     <= '0;
         out_cyc   <= '0;
         out_early <= 1'b0;
      end else begin
         if (accept) begin
            mul_a <= in_a;
            mul_b <= in_b;
            if (zero_op) begin
               out_z     <= '0;
               out_cyc   <= '0;
               out_early <= 1'b1;
            end
         end
         if (stop_ov || stop_lim) begin
            // ov takes precedence when it coincides with the limit
            out_early <= stop_ov;
         end
         if (state == ST_DRAIN) begin
            out_z   <= mul_z;
            out_cyc <= cnt;
         end
      end
   end

endmodule

// File: tb/tb_dsc_mul_es_ctrl.sv
module tb_dsc_mul_es_ctrl;
   import dsc_pkg::*;

   localparam int W = SNG_WIDTH;

   typedef struct packed {
      logic [2*W-1:0] z;
      logic [2*W:0]   cyc;
      logic           early;
   } res_t;

   logic           clk = 1'b0;
   logic           rst;
   logic           in_valid;
   logic           in_ready;
   logic [W-1:0]   in_a;
   logic [W-1:0]   in_b;
   logic           out_valid;
   logic           out_ready;
   logic [2*W-1:0] out_z;
   logic [2*W:0]   out_cyc;
   logic           out_early;
   logic [W-1:0]   mul_a;
   logic [W-1:0]   mul_b;
   logic           mul_en;
   logic           mul_rst;
   logic [2*W-1:0] mul_z;
   logic           mul_ov = 1'b0;

   int   checks = 0;
   int   errors = 0;
   res_t exp_q[$];

   // mul_ov plan: pulse on RUN cycle ov_k1 / ov_k2 (1-based), ov_out outside RUN
   int   run_k  = 0;
   int   ov_k1  = 0;
   int   ov_k2  = 0;
   bit   ov_out = 1'b0;
   int   en_cnt = 0;
   logic ph;

   always #5 clk = ~clk;

   dsc_mul_es_ctrl #(
      .W         (W),
      .IGNORE_OV (2)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_z     (out_z),
      .out_cyc   (out_cyc),
      .out_early (out_early),
      .mul_a     (mul_a),
      .mul_b     (mul_b),
      .mul_en    (mul_en),
      .mul_rst   (mul_rst),
      .mul_z     (mul_z),
      .mul_ov    (mul_ov)
   );

   // Stand-in core: count rises on every second enabled cycle, so after N
   // RUN cycles it holds N/2 and a capture one edge early would read less.
   always @(posedge clk) begin
      if (mul_rst === 1'b1) begin
         mul_z <= '0;
         ph    <= 1'b0;
      end else if (mul_en === 1'b1) begin
         if (ph) mul_z <= mul_z + 1'b1;
         ph <= ~ph;
      end
   end

   always @(negedge clk) begin
      if (mul_en === 1'b1) begin
         run_k  = run_k + 1;
         en_cnt = en_cnt + 1;
         mul_ov = (run_k == ov_k1) || (run_k == ov_k2);
      end else begin
         run_k  = 0;
         mul_ov = ov_out;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   function automatic res_t mk(input int z, input int cyc, input bit early);
      res_t r;
      r.z     = (2*W)'(z);
      r.cyc   = (2*W+1)'(cyc);
      r.early = early;
      return r;
   endfunction

   // Scoreboard monitor: pops one expectation per output handshake.
   always @(negedge clk) begin
      res_t e;
      if (rst === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_result actual=z%0h/c%0h required=no_result", out_z, out_cyc);
         end else begin
            e = exp_q.pop_front();
            chk("out_z", 32'(out_z), 32'(e.z));
            chk("out_cyc", 32'(out_cyc), 32'(e.cyc));
            chk("out_early", 32'(out_early), 32'(e.early));
         end
      end
   end

   // Called at a negedge; returns at the negedge right after the accept edge.
   task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input res_t e, input bit push);
      int i;
      for (i = 0; i < 2000 && in_ready !== 1'b1; i++) @(negedge clk);
      if (in_ready !== 1'b1) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout actual=in_ready_%b required=1", in_ready);
         return;
      end
      in_a     = a;
      in_b     = b;
      in_valid = 1'b1;
      @(posedge clk);
      if (push) exp_q.push_back(e);
      @(negedge clk);
      in_valid = 1'b0;
      in_a     = 4'hA;
      in_b     = 4'h5;
   endtask

   task automatic wait_idle();
      int i;
      for (i = 0; i < 2000 && !(in_ready === 1'b1 && exp_q.size() == 0); i++) @(negedge clk);
      if (!(in_ready === 1'b1 && exp_q.size() == 0)) begin
         checks++;
         errors++;
         $display("FAIL idle_timeout actual=in_ready_%b_pending_%0d required=idle", in_ready, exp_q.size());
      end
   endtask

   initial begin
      int en0;
      int i;
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_a      = '0;
      in_b      = '0;
      out_ready = 1'b1;

      repeat (3) @(negedge clk);
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_mul_rst", 32'(mul_rst), 1);
      chk("rst_mul_en", 32'(mul_en), 0);
      chk("rst_out_z", 32'(out_z), 0);
      rst = 1'b0;
      @(negedge clk);
      chk("rel_mul_rst", 32'(mul_rst), 0);
      chk("rel_in_ready", 32'(in_ready), 1);

      // zero bypass
      en0 = en_cnt;
      issue(4'h0, 4'h9, mk(0, 0, 1'b1), 1'b1);
      chk("bypass_latency", 32'(out_valid), 1);
      chk("bypass_in_ready", 32'(in_ready), 0);
      chk("bypass_mul_b", 32'(mul_b), 32'h9);
      wait_idle();
      chk("bypass_no_en", 32'(en_cnt), 32'(en0));

      // ov at RUN cycle 1 masked, stop at 40; ov also high outside RUN
      ov_k1  = 1;
      ov_k2  = 40;
      ov_out = 1'b1;
      issue(4'h8, 4'h4, mk(20, 40, 1'b1), 1'b1);
      @(negedge clk);
      chk("hold_mul_a", 32'(mul_a), 32'h8);
      chk("hold_mul_b", 32'(mul_b), 32'h4);
      wait_idle();
      ov_k1  = 0;
      ov_k2  = 0;
      ov_out = 1'b0;

      // ov at cycle 2 still masked, cycle 3 is the first honoured one
      ov_k1 = 2;
      ov_k2 = 3;
      issue(4'h2, 4'h3, mk(1, 3, 1'b1), 1'b1);
      wait_idle();
      ov_k1 = 0;
      ov_k2 = 0;

      // full window, no ov
      issue(4'hF, 4'hF, mk(128, 256, 1'b0), 1'b1);
      wait_idle();

      // ov coincides with limit
      ov_k2 = 256;
      issue(4'h5, 4'h7, mk(128, 256, 1'b1), 1'b1);
      wait_idle();
      ov_k2 = 0;

      // back-pressure in HOLD
      out_ready = 1'b0;
      ov_k2     = 10;
      issue(4'h3, 4'h5, mk(5, 10, 1'b1), 1'b1);
      for (i = 0; i < 100 && out_valid !== 1'b1; i++) @(negedge clk);
      chk("bp_out_valid", 32'(out_valid), 1);
      for (int k = 0; k < 10; k++) begin
         in_valid = 1'b1;
         in_a     = 4'hC;
         in_b     = 4'h6;
         @(negedge clk);
         chk("bp_valid", 32'(out_valid), 1);
         chk("bp_z", 32'(out_z), 5);
         chk("bp_cyc", 32'(out_cyc), 10);
         chk("bp_in_ready", 32'(in_ready), 0);
         chk("bp_mul_a", 32'(mul_a), 32'h3);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      ov_k2     = 0;
      wait_idle();
      chk("bp_released", 32'(out_valid), 0);

      // reset in the middle of RUN
      issue(4'hF, 4'hF, mk(0, 0, 1'b0), 1'b0);
      repeat (20) @(negedge clk);
      chk("mid_run_en", 32'(mul_en), 1);
      rst = 1'b1;
      #1;
      chk("mrst_out_valid", 32'(out_valid), 0);
      chk("mrst_mul_en", 32'(mul_en), 0);
      chk("mrst_mul_rst", 32'(mul_rst), 1);
      chk("mrst_out_z", 32'(out_z), 0);
      chk("mrst_out_cyc", 32'(out_cyc), 0);
      chk("mrst_out_early", 32'(out_early), 0);
      chk("mrst_mul_a", 32'(mul_a), 0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("mrst_in_ready", 32'(in_ready), 1);
      chk("mrst_rst_drop", 32'(mul_rst), 0);
      chk("mrst_idle_en", 32'(mul_en), 0);

      // normal operation resumes after the abort
      ov_k2 = 6;
      issue(4'h1, 4'h1, mk(3, 6, 1'b1), 1'b1);
      wait_idle();
      ov_k2 = 0;

      chk("queue_empty", 32'(exp_q.size()), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
